// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider controller for DIV: drives the shared ALU subtractor
// through magnitude, WIDTH shift/trial-subtract steps and sign fix-up.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] sub_a,
    output logic [WIDTH-1:0] sub_b,
    output logic             sub_cin,
    input  logic [WIDTH-1:0] sub_diff,
    input  logic             sub_cout,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ABS_A = 3'd1,
        S_ABS_B = 3'd2,
        S_ITER  = 3'd3,
        S_FIX_Q = 3'd4,
        S_FIX_R = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t           state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [WIDTH-1:0] dividend_r, dividend_s;
    logic [WIDTH-1:0] divisor_r, divisor_s;
    logic             signed_r, signed_s;
    logic [WIDTH-1:0] absb_r, absb_s;
    logic [WIDTH-1:0] rem_work_r, rem_work_s;
    logic [WIDTH-1:0] quo_work_r, quo_work_s;
    logic [WIDTH-1:0] quotient_r, quotient_s;
    logic [WIDTH-1:0] remainder_r, remainder_s;
    logic             dbz_r, dbz_s;
    logic             done_r, done_s;
    logic             busy_r, busy_s;
    logic [WIDTH-1:0] sub_a_r, sub_a_s;
    logic [WIDTH-1:0] sub_b_r, sub_b_s;

    logic             neg_a_s;
    logic             neg_b_s;
    logic [WIDTH-1:0] shifted_s;
    logic             ok_s;

    assign neg_a_s   = signed_r & dividend_r[WIDTH-1];
    assign neg_b_s   = signed_r & divisor_r[WIDTH-1];
    assign shifted_s = {rem_work_r[WIDTH-2:0], quo_work_r[WIDTH-1]};
    // R[MSB] set means the true shifted partial remainder exceeds any divisor
    assign ok_s      = sub_cout | rem_work_r[WIDTH-1];

    // Next-state, datapath updates, and subtractor operands for the upcoming state
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        dividend_s  = dividend_r;
        divisor_s   = divisor_r;
        signed_s    = signed_r;
        absb_s      = absb_r;
        rem_work_s  = rem_work_r;
        quo_work_s  = quo_work_r;
        quotient_s  = quotient_r;
        remainder_s = remainder_r;
        dbz_s       = dbz_r;
        sub_a_s     = {WIDTH{1'b0}};
        sub_b_s     = {WIDTH{1'b0}};

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    dividend_s = dividend;
                    divisor_s  = divisor;
                    signed_s   = signed_op;
                    if (divisor == {WIDTH{1'b0}}) begin
                        state_s     = S_DONE;
                        dbz_s       = 1'b1;
                        quotient_s  = {WIDTH{1'b1}};
                        remainder_s = dividend;
                    end else begin
                        state_s = S_ABS_A;
                        dbz_s   = 1'b0;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ABS_A: begin
                quo_work_s = neg_a_s ? sub_diff : dividend_r;
                state_s    = S_ABS_B;
            end
            S_ABS_B: begin
                absb_s     = neg_b_s ? sub_diff : divisor_r;
                rem_work_s = {WIDTH{1'b0}};
                cnt_s      = CW'(WIDTH - 1);
                state_s    = S_ITER;
            end
            S_ITER: begin
                rem_work_s = ok_s ? sub_diff : shifted_s;
                quo_work_s = {quo_work_r[WIDTH-2:0], ok_s};
                if (cnt_r == {CW{1'b0}}) begin
                    state_s = S_FIX_Q;
                end else begin
                    cnt_s = cnt_r - CW'(1);
                end
            end
            S_FIX_Q: begin
                quotient_s = (neg_a_s ^ neg_b_s) ? sub_diff : quo_work_r;
                state_s    = S_FIX_R;
            end
            S_FIX_R: begin
                remainder_s = neg_a_s ? sub_diff : rem_work_r;
                state_s     = S_DONE;
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        // Operands are registered, so they are chosen for the state being entered
        case (state_s)
            S_ABS_A: sub_b_s = dividend_s;
            S_ABS_B: sub_b_s = divisor_s;
            S_ITER: begin
                sub_a_s = {rem_work_s[WIDTH-2:0], quo_work_s[WIDTH-1]};
                sub_b_s = absb_s;
            end
            S_FIX_Q: sub_b_s = quo_work_s;
            S_FIX_R: sub_b_s = rem_work_s;
            default: begin
                sub_a_s = {WIDTH{1'b0}};
                sub_b_s = {WIDTH{1'b0}};
            end
        endcase

        busy_s = (state_s != S_IDLE);
        done_s = (state_s == S_DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            cnt_r       <= {CW{1'b0}};
            dividend_r  <= {WIDTH{1'b0}};
            divisor_r   <= {WIDTH{1'b0}};
            signed_r    <= 1'b0;
            absb_r      <= {WIDTH{1'b0}};
            rem_work_r  <= {WIDTH{1'b0}};
            quo_work_r  <= {WIDTH{1'b0}};
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dbz_r       <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            sub_a_r     <= {WIDTH{1'b0}};
            sub_b_r     <= {WIDTH{1'b0}};
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            dividend_r  <= dividend_s;
            divisor_r   <= divisor_s;
            signed_r    <= signed_s;
            absb_r      <= absb_s;
            rem_work_r  <= rem_work_s;
            quo_work_r  <= quo_work_s;
            quotient_r  <= quotient_s;
            remainder_r <= remainder_s;
            dbz_r       <= dbz_s;
            done_r      <= done_s;
            busy_r      <= busy_s;
            sub_a_r     <= sub_a_s;
            sub_b_r     <= sub_b_s;
        end
    end

    assign sub_a       = sub_a_r;
    assign sub_b       = sub_b_r;
    assign sub_cin     = 1'b0;
    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed and random checks of div_sequencer against an arithmetic reference model,
// with a behavioural subtractor closing the loop.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] sub_a;
    logic [31:0] sub_b;
    logic        sub_cin;
    logic [31:0] sub_diff;
    logic        sub_cout;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int vectors = 0;
    int miscompares = 0;

    div_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor),
        .sub_a(sub_a), .sub_b(sub_b), .sub_cin(sub_cin),
        .sub_diff(sub_diff), .sub_cout(sub_cout),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    assign sub_diff = sub_a - sub_b - {31'd0, sub_cin};
    assign sub_cout = (sub_a >= sub_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference divide: magnitudes, truncation toward zero, remainder follows dividend sign
    task automatic ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r, output logic dz);
        logic        na, nb;
        logic [31:0] ma, mb, q0, r0;
        if (b == 32'd0) begin
            dz = 1'b1; q = 32'hFFFF_FFFF; r = a;
        end else begin
            dz = 1'b0;
            na = s & a[31];
            nb = s & b[31];
            ma = na ? (32'd0 - a) : a;
            mb = nb ? (32'd0 - b) : b;
            q0 = ma / mb;
            r0 = ma % mb;
            q  = (na ^ nb) ? (32'd0 - q0) : q0;
            r  = na ? (32'd0 - r0) : r0;
        end
    endtask

    // mode 0: plain op; 1: stray start at cycle 10; 2: reset at cycle 10
    task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                          input logic edz, input int mode);
        int c;
        int lat;
        lat = (b == 32'd0) ? 1 : 37;
        @(negedge clk);
        start = 1'b1; signed_op = s; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom; signed_op = ~s;
        c = 1;
        while (1) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            if (done || c >= 60) break;
            if (c == 10 && mode == 1) begin
                start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
            end else if (c == 10 && mode == 2) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                chk({tag, "_rst_busy"}, {31'd0, busy}, 32'd0);
                chk({tag, "_rst_done"}, {31'd0, done}, 32'd0);
                chk({tag, "_rst_dbz"}, {31'd0, div_by_zero}, 32'd0);
                chk({tag, "_rst_q"}, quotient, 32'd0);
                chk({tag, "_rst_r"}, remainder, 32'd0);
                chk({tag, "_rst_suba"}, sub_a, 32'd0);
                chk({tag, "_rst_subb"}, sub_b, 32'd0);
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk); #1;
                    chk({tag, "_rst_nodone"}, {31'd0, done}, 32'd0);
                end
                return;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            c++;
        end
        chk({tag, "_latency"}, c, lat);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edz});
        @(posedge clk); #1;
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_idle_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle_suba"}, sub_a, 32'd0);
        chk({tag, "_idle_subb"}, sub_b, 32'd0);
        chk({tag, "_hold_q"}, quotient, eq);
        chk({tag, "_hold_r"}, remainder, er);
    endtask

    initial begin
        logic [31:0] ra, rb, rq, rr;
        logic        rs, rdz;
        reset = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = 32'd0; divisor = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_q", quotient, 32'd0);
        chk("reset_r", remainder, 32'd0);
        chk("reset_suba", sub_a, 32'd0);
        chk("reset_subb", sub_b, 32'd0);
        chk("sub_cin", {31'd0, sub_cin}, 32'd0);
        reset = 1'b0;

        run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);
        run_op("sm100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 0);
        run_op("s100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 0);
        run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 0);
        run_op("u_big", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b0, 0);
        run_op("dbz", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
        run_op("after_dbz", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 0);
        run_op("ignored_start", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1);
        run_op("reset_mid", 1'b0, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 2);
        run_op("after_reset", 1'b0, 32'd44, 32'd4, 32'd11, 32'd0, 1'b0, 0);

        for (int n = 0; n < 12; n++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case (n % 4)
                0: rb = $urandom;
                1: rb = $urandom_range(1, 100);
                2: rb = 32'd0 - $urandom_range(1, 100);
                default: rb = (n == 7) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            endcase
            ref_div(rs, ra, rb, rq, rr, rdz);
            run_op("random", rs, ra, rb, rq, rr, rdz, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
